led_pattern_sequencer: RTL and testbench

Pattern controller for the four-LED blink datapath. Divides `clk` down to a step rate and advances one of four selectable LED patterns on each step. A debounced push-button cycles through the patterns. Sits between the board button and the `led1`..`led4` pins, replacing the fixed blink logic with a sequenced, mode-selectable one.

---
 rtl/led_pattern_sequencer.sv | 162 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives four LEDs with one of four selectable patterns. A prescaler divides clk down
//   to the step rate, and a debounced push-button selects the next pattern mode.
//
// Parameters
//   TICK_DIV   clock cycles per pattern step (>= 2)
//   DB_CYCLES  consecutive stable synchronized samples needed to accept a button change (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         step enable; when low the prescaler phase and pattern are frozen
//   btn        raw asynchronous mode button, active-high
//   led1..led4 pattern bits 0..3 (registered)
//   mode       current pattern mode: 0 ALL_BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT (registered)
//   step_tick  one-cycle pulse, high in the cycle a new stepped pattern first appears

module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV  = 8,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);

    typedef enum logic {
        DirUp,
        DirDown
    } dir_t;

    // State
    logic [1:0]    sync_q;
    logic          db_level_q;
    logic [DW-1:0] db_cnt_q;
    logic [1:0]    mode_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    pat_q;
    dir_t          dir_q;
    logic          step_tick_q;

    // Next-state helpers
    logic       sb;
    logic       press;
    logic [1:0] mode_next;
    logic       pat_onehot;
    logic [3:0] step_pat;
    dir_t       step_dir;
    logic [3:0] init_pat;

    assign sb        = sync_q[1];
    // A press is the edge on which the debounced level is accepted as 0 -> 1.
    assign press     = (sb != db_level_q) && (db_cnt_q == DB_MAX) && sb;
    assign mode_next = mode_q + 2'd1;
    assign pat_onehot = (pat_q != 4'b0000) && ((pat_q & (pat_q - 4'd1)) == 4'b0000);

    // Pattern produced by one step in the current mode.
    always_comb begin
        step_pat = pat_q;
        step_dir = dir_q;
        case (mode_q)
            2'd0: step_pat = ~pat_q;
            2'd1: step_pat = pat_onehot ? {pat_q[2:0], pat_q[3]} : 4'b0001;
            2'd2: begin
                // Ends are handled explicitly so the bounce never stalls or repeats an end.
                if (!pat_onehot) begin
                    step_pat = 4'b0001;
                end else if (pat_q == 4'b1000) begin
                    step_pat = 4'b0100;
                end else if (pat_q == 4'b0001) begin
                    step_pat = 4'b0010;
                end else if (dir_q == DirUp) begin
                    step_pat = pat_q << 1;
                end else begin
                    step_pat = pat_q >> 1;
                end
                if (step_pat == 4'b1000) begin
                    step_dir = DirDown;
                end else if (step_pat == 4'b0001) begin
                    step_dir = DirUp;
                end
            end
            default: step_pat = pat_q + 4'd1;
        endcase
    end

    // Initial pattern of the mode being entered on a press.
    always_comb begin
        init_pat = 4'b0000;
        case (mode_next)
            2'd1, 2'd2: init_pat = 4'b0001;
            default:    init_pat = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= 2'b00;
            db_level_q  <= 1'b0;
            db_cnt_q    <= '0;
            mode_q      <= 2'd0;
            cnt_q       <= '0;
            pat_q       <= 4'b0000;
            dir_q       <= DirUp;
            step_tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};

            // Debouncer: count consecutive samples that disagree with the accepted level.
            if (sb == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_MAX) begin
                db_level_q <= sb;
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end

            // A press wins over a coincident step and restarts the step phase.
            if (press) begin
                mode_q      <= mode_next;
                cnt_q       <= '0;
                step_tick_q <= 1'b0;
                pat_q       <= init_pat;
                dir_q       <= DirUp;
            end else if (en) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_q       <= '0;
                    pat_q       <= step_pat;
                    dir_q       <= step_dir;
                    step_tick_q <= 1'b1;
                end else begin
                    cnt_q       <= cnt_q + 1'b1;
                    step_tick_q <= 1'b0;
                end
            end else begin
                step_tick_q <= 1'b0;
            end
        end
    end

    assign led1      = pat_q[0];
    assign led2      = pat_q[1];
    assign led3      = pat_q[2];
    assign led4      = pat_q[3];
    assign mode      = mode_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer: step expectations (edge number, pattern, mode) are
// queued as stimulus is applied and popped by a monitor whenever step_tick is seen.

module tb_led_pattern_sequencer;

    localparam int TD = 8;
    localparam int DB = 4;

    localparam logic [3:0] BOUNCE [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    typedef struct {
        int         cyc;
        logic [3:0] pat;
        logic [1:0] mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic       btn = 1'b0;
    logic       led1, led2, led3, led4;
    logic [1:0] mode;
    logic       step_tick;
    logic [3:0] leds;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic sb_on    = 1'b0;
    logic prev_tick = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    int dbc;       // mode-change edge of the debounce press
    int s_ref;     // edge of the step following the enable freeze
    int sim_chg;   // mode-change edge aligned with a step edge

    assign leds = {led4, led3, led2, led1};

    led_pattern_sequencer #(
        .TICK_DIV (TD),
        .DB_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn      (btn),
        .led1     (led1),
        .led2     (led2),
        .led3     (led3),
        .led4     (led4),
        .mode     (mode),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (sb_on && rst && step_tick) begin
            checks++;
            if (prev_tick) begin
                failures++;
                $display("FAIL step_tick_double at cyc=%0d: got two consecutive highs, want one", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step cyc=%0d leds=%b mode=%0d, want no step", cyc, leds, mode);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || leds !== mon_e.pat || mode !== mon_e.mode) begin
                    failures++;
                    $display("FAIL step_match got cyc=%0d leds=%b mode=%0d, want cyc=%0d leds=%b mode=%0d",
                             cyc, leds, mode, mon_e.cyc, mon_e.pat, mon_e.mode);
                end
            end
        end
        prev_tick = step_tick;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int c, input logic [3:0] p, input logic [1:0] m);
        exp_t t;
        t.cyc  = c;
        t.pat  = p;
        t.mode = m;
        exp_q.push_back(t);
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Let the monitor consume pending expectations; report how many remain.
    task automatic drain(output int left);
        int n = 0;
        #1;
        while (exp_q.size() != 0 && n < 4 * TD) begin
            @(negedge clk);
            #1;
            n++;
        end
        left = exp_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int ref_c, left;
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        checks++;
        if (leds !== 4'b0000 || mode !== 2'd0 || step_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_state leds=%b mode=%0d tick=%b, want 0000 0 0", leds, mode, step_tick);
        end
        @(negedge clk);
        rst   = 1'b1;
        ref_c = cyc;
        sb_on = 1'b1;
        push_exp(ref_c + TD, 4'b1111, 2'd0);
        push_exp(ref_c + 2 * TD, 4'b0000, 2'd0);
        wait_until(ref_c + 2 * TD);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL reset_steps_missing left=%0d, want 0", left);
        end
        sb_on = 1'b0;
    endtask

    task automatic test_mode_sequence();
        int e, c, left;
        // CHASE
        @(negedge clk);
        btn = 1'b1;
        e = cyc + 1;
        c = e + DB + 1;
        wait_until(c);
        checks++;
        if (mode !== 2'd1 || leds !== 4'b0001 || step_tick !== 1'b0) begin
            failures++;
            $display("FAIL chase_load mode=%0d leds=%b tick=%b, want 1 0001 0", mode, leds, step_tick);
        end
        sb_on = 1'b1;
        for (int k = 1; k <= 4; k++) push_exp(c + TD * k, 4'b0001 << (k % 4), 2'd1);
        wait_until(e + 9);
        btn = 1'b0;
        wait_until(c + 4 * TD);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL chase_steps_missing left=%0d, want 0", left);
        end
        sb_on = 1'b0;
        // BOUNCE
        @(negedge clk);
        btn = 1'b1;
        e = cyc + 1;
        c = e + DB + 1;
        wait_until(c);
        checks++;
        if (mode !== 2'd2 || leds !== 4'b0001) begin
            failures++;
            $display("FAIL bounce_load mode=%0d leds=%b, want 2 0001", mode, leds);
        end
        sb_on = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(c + TD * (k + 1), BOUNCE[k], 2'd2);
        wait_until(e + 9);
        btn = 1'b0;
        wait_until(c + 6 * TD);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL bounce_steps_missing left=%0d, want 0", left);
        end
        sb_on = 1'b0;
    endtask

    task automatic test_count_wrap();
        int e, c, left;
        @(negedge clk);
        btn = 1'b1;
        e = cyc + 1;
        c = e + DB + 1;
        wait_until(c);
        checks++;
        if (mode !== 2'd3 || leds !== 4'b0000) begin
            failures++;
            $display("FAIL count_load mode=%0d leds=%b, want 3 0000", mode, leds);
        end
        sb_on = 1'b1;
        for (int k = 1; k <= 16; k++) push_exp(c + TD * k, 4'(k), 2'd3);
        wait_until(e + 9);
        btn = 1'b0;
        wait_until(c + 16 * TD);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL count_steps_missing left=%0d, want 0", left);
        end
        sb_on = 1'b0;
        // Fourth press wraps back to ALL_BLINK
        @(negedge clk);
        btn = 1'b1;
        e = cyc + 1;
        c = e + DB + 1;
        wait_until(c);
        checks++;
        if (mode !== 2'd0 || leds !== 4'b0000) begin
            failures++;
            $display("FAIL mode_wrap mode=%0d leds=%b, want 0 0000", mode, leds);
        end
        sb_on = 1'b1;
        push_exp(c + TD, 4'b1111, 2'd0);
        wait_until(e + 9);
        btn = 1'b0;
        wait_until(c + TD);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL blink_after_wrap_missing left=%0d, want 0", left);
        end
        sb_on = 1'b0;
    endtask

    task automatic test_debounce();
        int e, c;
        @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL glitch_3cyc mode=%0d, want 0", mode);
        end
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            repeat (2) @(negedge clk);
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL toggle_2cyc mode=%0d, want 0", mode);
        end
        btn = 1'b1;
        e = cyc + 1;
        c = e + DB + 1;
        wait_until(c);
        checks++;
        if (mode !== 2'd1 || leds !== 4'b0001) begin
            failures++;
            $display("FAIL pulse_6cyc mode=%0d leds=%b, want 1 0001", mode, leds);
        end
        btn = 1'b0;
        dbc = c;
        repeat (20) @(negedge clk);
        checks++;
        if (mode !== 2'd1) begin
            failures++;
            $display("FAIL release_no_change mode=%0d, want 1", mode);
        end
    endtask

    task automatic test_enable_freeze();
        int k, s, left;
        logic [3:0] pk;
        logic [3:0] pn;
        k  = (cyc - dbc) / TD + 1;
        s  = dbc + TD * k;
        pk = 4'b0001 << (k % 4);
        pn = 4'b0001 << ((k + 1) % 4);
        sb_on = 1'b1;
        push_exp(s, pk, 2'd1);
        wait_until(s + 5);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (leds !== pk || step_tick !== 1'b0) begin
                failures++;
                $display("FAIL freeze cyc=%0d leds=%b tick=%b, want %b 0", cyc, leds, step_tick, pk);
            end
        end
        en = 1'b1;
        push_exp(s + 28, pn, 2'd1);
        wait_until(s + 28);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL resume_step_missing left=%0d, want 0", left);
        end
        s_ref = s + 28;
    endtask

    task automatic test_simultaneous();
        int e, c, left;
        c = s_ref + TD;
        wait_until(c - DB - 2);
        btn = 1'b1;
        e = cyc + 1;
        wait_until(c);
        checks++;
        if (mode !== 2'd2 || leds !== 4'b0001 || step_tick !== 1'b0) begin
            failures++;
            $display("FAIL press_on_step mode=%0d leds=%b tick=%b, want 2 0001 0", mode, leds, step_tick);
        end
        for (int k = 0; k < 4; k++) push_exp(c + TD * (k + 1), BOUNCE[k], 2'd2);
        wait_until(e + 9);
        btn = 1'b0;
        wait_until(c + 4 * TD);
        drain(left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL bounce_down_missing left=%0d, want 0", left);
        end
        sim_chg = c;
    endtask

    task automatic test_reset_mid();
        int ref_c, left;
        wait_until(sim_chg + 4 * TD + 2);
        checks++;
        if (mode !== 2'd2 || leds !== 4'b0100) begin
            failures++;
            $display("FAIL pre_reset mode=%0d leds=%b, want 2 0100", mode, leds);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (leds !== 4'b0000 || mode !== 2'd0 || step_tick !== 1'b0) begin
            failures++;
            $display("FAIL async_reset leds=%b mode=%0d tick=%b, want 0000 0 0", leds, mode, step_tick);
        end
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        ref_c = cyc;
        push_exp(ref_c + TD, 4'b1111, 2'd0);
        wait_until(ref_c + TD);
        drain(left);
        checks++;
        if (left != 0 || mode !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_step left=%0d mode=%0d, want 0 0", left, mode);
        end
        sb_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_sequence();
        test_count_wrap();
        test_debounce();
        test_enable_freeze();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
